// File: rtl/dcache_route_mux_pkg.sv
// dcache_route_mux_pkg: shared route encodings and default uncached window for the data-port router.
package dcache_route_mux_pkg;
   localparam logic ROUTE_CACHE = 1'b0;
   localparam logic ROUTE_BYPASS = 1'b1;
   localparam logic [31:0] UC_MASK_DEF = 32'hE000_0000;
   localparam logic [31:0] UC_MATCH_DEF = 32'hA000_0000;
endpackage

// File: rtl/dcache_route_mux_route_tracker.sv
// route_tracker: outstanding count and owning route so responses retire in order from the right path.
module route_tracker
   import dcache_route_mux_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic uc,
   input  logic accept,
   input  logic cache_data_ok,
   input  logic bridge_data_ok,
   output logic issue_ok,
   output logic retire,
   output logic route,
   output logic busy,
   output logic err_stray
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
   logic [CW-1:0] count;
   logic path_ok, other_ok, stray;
   assign path_ok = route ? bridge_data_ok : cache_data_ok;
   assign other_ok = route ? cache_data_ok : bridge_data_ok;
   assign busy = count != '0;
   assign retire = busy & path_ok;
   // a data_ok with nothing outstanding, or from the path not owning the queue, is dropped
   assign stray = other_ok | (!busy & path_ok);
   assign issue_ok = !rst & (!busy | (uc == route & count < MAX_C));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count <= '0;
         route <= ROUTE_CACHE;
         err_stray <= 1'b0;
      end else begin
         count <= count + CW'(accept) - CW'(retire);
         if (accept && !busy) route <= uc;
         if (stray) err_stray <= 1'b1;
      end
endmodule

// File: rtl/dcache_route_mux.sv
// dcache_route_mux: per-request cached/uncached router for the CPU data port with perf counters.
module dcache_route_mux
   import dcache_route_mux_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter logic [ADDR_W-1:0] UC_MASK = ADDR_W'(UC_MASK_DEF),
   parameter logic [ADDR_W-1:0] UC_MATCH = ADDR_W'(UC_MATCH_DEF),
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              force_uncached,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic [DATA_W-1:0] data_rdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic              tocache_req,
   output logic              tocache_wr,
   output logic [1:0]        tocache_size,
   output logic [ADDR_W-1:0] tocache_addr,
   output logic [DATA_W-1:0] tocache_wdata,
   input  logic [DATA_W-1:0] fromcache_rdata,
   input  logic              fromcache_addr_ok,
   input  logic              fromcache_data_ok,
   output logic              tobridge_req,
   output logic              tobridge_wr,
   output logic [1:0]        tobridge_size,
   output logic [ADDR_W-1:0] tobridge_addr,
   output logic [DATA_W-1:0] tobridge_wdata,
   input  logic [DATA_W-1:0] frombridge_rdata,
   input  logic              frombridge_addr_ok,
   input  logic              frombridge_data_ok,
   output logic              busy,
   output logic              err_stray,
   output logic [CNT_W-1:0]  cnt_cached,
   output logic [CNT_W-1:0]  cnt_uncached,
   output logic [CNT_W-1:0]  cnt_switch_stall
);
   logic uc, route, issue_ok, accept, retire, switch_stall;
   assign uc = force_uncached | ((data_addr & UC_MASK) == UC_MATCH);
   assign data_addr_ok = issue_ok & (uc ? frombridge_addr_ok : fromcache_addr_ok);
   assign accept = data_req & data_addr_ok;
   assign switch_stall = data_req & busy & (uc != route);
   assign tocache_req = data_req & issue_ok & (uc == ROUTE_CACHE);
   assign tocache_wr = (uc == ROUTE_CACHE) & data_wr;
   assign tocache_size = uc ? '0 : data_size;
   assign tocache_addr = uc ? '0 : data_addr;
   assign tocache_wdata = uc ? '0 : data_wdata;
   assign tobridge_req = data_req & issue_ok & (uc == ROUTE_BYPASS);
   assign tobridge_wr = (uc == ROUTE_BYPASS) & data_wr;
   assign tobridge_size = uc ? data_size : '0;
   assign tobridge_addr = uc ? data_addr : '0;
   assign tobridge_wdata = uc ? data_wdata : '0;
   assign data_rdata = route ? frombridge_rdata : fromcache_rdata;
   assign data_data_ok = retire;
   route_tracker #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_tracker (
      .clk(clk),
      .rst(rst),
      .uc(uc),
      .accept(accept),
      .cache_data_ok(fromcache_data_ok),
      .bridge_data_ok(frombridge_data_ok),
      .issue_ok(issue_ok),
      .retire(retire),
      .route(route),
      .busy(busy),
      .err_stray(err_stray)
   );
   // perf counters stick at all-ones instead of wrapping
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt_cached <= '0;
         cnt_uncached <= '0;
         cnt_switch_stall <= '0;
      end else begin
         if (accept && !uc && !(&cnt_cached)) cnt_cached <= cnt_cached + CNT_W'(1);
         if (accept && uc && !(&cnt_uncached)) cnt_uncached <= cnt_uncached + CNT_W'(1);
         if (switch_stall && !(&cnt_switch_stall)) cnt_switch_stall <= cnt_switch_stall + CNT_W'(1);
      end
endmodule

// File: tb/tb_dcache_route_mux.sv
// tb_dcache_route_mux: scoreboard bench; expected read data queued at issue, checked on data_data_ok.
module tb_dcache_route_mux;
   logic clk = 1'b0, rst = 1'b1, force_uncached = 1'b0;
   logic data_req = 1'b0, data_wr = 1'b0;
   logic [1:0] data_size = 2'd2;
   logic [31:0] data_addr = '0, data_wdata = '0, data_rdata;
   logic data_addr_ok, data_data_ok;
   logic tocache_req, tocache_wr, tobridge_req, tobridge_wr;
   logic [1:0] tocache_size, tobridge_size;
   logic [31:0] tocache_addr, tocache_wdata, tobridge_addr, tobridge_wdata;
   logic [31:0] fromcache_rdata = '0, frombridge_rdata = '0;
   logic fromcache_addr_ok = 1'b1, fromcache_data_ok = 1'b0;
   logic frombridge_addr_ok = 1'b1, frombridge_data_ok = 1'b0;
   logic busy, err_stray;
   logic [31:0] cnt_cached, cnt_uncached, cnt_switch_stall;
   int vectors = 0, miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   dcache_route_mux dut (
      .clk(clk), .rst(rst), .force_uncached(force_uncached),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .tocache_req(tocache_req), .tocache_wr(tocache_wr), .tocache_size(tocache_size),
      .tocache_addr(tocache_addr), .tocache_wdata(tocache_wdata),
      .fromcache_rdata(fromcache_rdata), .fromcache_addr_ok(fromcache_addr_ok),
      .fromcache_data_ok(fromcache_data_ok),
      .tobridge_req(tobridge_req), .tobridge_wr(tobridge_wr), .tobridge_size(tobridge_size),
      .tobridge_addr(tobridge_addr), .tobridge_wdata(tobridge_wdata),
      .frombridge_rdata(frombridge_rdata), .frombridge_addr_ok(frombridge_addr_ok),
      .frombridge_data_ok(frombridge_data_ok),
      .busy(busy), .err_stray(err_stray),
      .cnt_cached(cnt_cached), .cnt_uncached(cnt_uncached), .cnt_switch_stall(cnt_switch_stall)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (data_data_ok) begin
         if (exp_q.size() == 0) chk("unexpected_data_ok", 1, 0);
         else chk("rdata", data_rdata, exp_q.pop_front());
      end
   end

   task automatic send(input logic [31:0] a, input logic w, input logic byp, input logic [31:0] rd);
      @(negedge clk);
      data_req = 1'b1; data_wr = w; data_addr = a; data_wdata = ~a;
      #2;
      chk("addr_ok", data_addr_ok, 1);
      chk("cache_req", tocache_req, !byp);
      chk("bridge_req", tobridge_req, byp);
      if (byp) begin
         chk("bridge_addr", tobridge_addr, a);
         chk("bridge_wr", tobridge_wr, w);
      end else chk("cache_addr", tocache_addr, a);
      exp_q.push_back(rd);
      @(posedge clk); #1 data_req = 1'b0;
   endtask

   task automatic respond(input logic byp, input logic [31:0] rd);
      @(negedge clk);
      if (byp) begin frombridge_data_ok = 1'b1; frombridge_rdata = rd; end
      else begin fromcache_data_ok = 1'b1; fromcache_rdata = rd; end
      @(posedge clk); #1;
      fromcache_data_ok = 1'b0; frombridge_data_ok = 1'b0;
   endtask

   task automatic hold_req(input logic [31:0] a);
      data_req = 1'b1; data_wr = 1'b0; data_addr = a;
   endtask

   initial begin
      hold_req(32'h8000_0000);
      fromcache_data_ok = 1'b1; fromcache_rdata = 32'h0000_00C5; frombridge_rdata = 32'h0000_00B5;
      #3;
      chk("rst_addr_ok", data_addr_ok, 0);
      chk("rst_cache_req", tocache_req, 0);
      chk("rst_data_ok", data_data_ok, 0);
      chk("rst_rdata", data_rdata, 32'h0000_00C5);
      chk("rst_busy", busy, 0);
      chk("rst_stray", err_stray, 0);
      chk("rst_cnt", {cnt_cached, cnt_uncached} | {32'h0, cnt_switch_stall}, 0);
      @(negedge clk);
      data_req = 1'b0; fromcache_data_ok = 1'b0;
      @(negedge clk) rst = 1'b0;
      // cached load, answered three cycles after issue
      send(32'h8000_0010, 1'b0, 1'b0, 32'h1234_5678);
      chk("busy_after_issue", busy, 1);
      @(negedge clk); @(negedge clk);
      respond(1'b0, 32'h1234_5678);
      @(negedge clk) #2;
      chk("t1_cached", cnt_cached, 1);
      chk("t1_busy", busy, 0);
      // uncached store
      send(32'hBFAF_0000, 1'b1, 1'b1, 32'h0);
      respond(1'b1, 32'h0);
      @(negedge clk) #2;
      chk("t2_uncached", cnt_uncached, 1);
      // fill to MAX_OUTSTANDING, fifth waits for first retire
      for (int i = 0; i < 4; i++) send(32'h8000_0000 + 32'(i * 4), 1'b0, 1'b0, 32'hA0 + 32'(i));
      @(negedge clk);
      hold_req(32'h8000_0040);
      #2;
      chk("full_addr_ok", data_addr_ok, 0);
      chk("full_cache_req", tocache_req, 0);
      @(negedge clk);
      fromcache_data_ok = 1'b1; fromcache_rdata = 32'hA0;
      #2 chk("full_retire_addr_ok", data_addr_ok, 0);
      @(posedge clk); #1 fromcache_data_ok = 1'b0;
      @(negedge clk) #2;
      chk("full_release", data_addr_ok, 1);
      exp_q.push_back(32'hA4);
      @(posedge clk); #1 data_req = 1'b0;
      for (int i = 1; i < 5; i++) respond(1'b0, 32'hA0 + 32'(i));
      @(negedge clk) #2;
      chk("full_no_switch_stall", cnt_switch_stall, 0);
      chk("full_cached", cnt_cached, 6);
      // class switch waits for the cached read to drain
      send(32'h8000_0100, 1'b0, 1'b0, 32'hB0);
      @(negedge clk);
      hold_req(32'hA000_0040);
      #2;
      chk("sw_addr_ok1", data_addr_ok, 0);
      chk("sw_bridge_req1", tobridge_req, 0);
      chk("sw_cache_req1", tocache_req, 0);
      @(negedge clk) #2 chk("sw_addr_ok2", data_addr_ok, 0);
      @(negedge clk);
      fromcache_data_ok = 1'b1; fromcache_rdata = 32'hB0;
      #2 chk("sw_addr_ok3", data_addr_ok, 0);
      @(posedge clk); #1 fromcache_data_ok = 1'b0;
      @(negedge clk) #2;
      chk("sw_addr_ok4", data_addr_ok, 1);
      chk("sw_bridge_req4", tobridge_req, 1);
      chk("sw_stall_cnt", cnt_switch_stall, 3);
      exp_q.push_back(32'hC0);
      @(posedge clk); #1 data_req = 1'b0;
      respond(1'b1, 32'hC0);
      // forced uncached
      force_uncached = 1'b1;
      send(32'h8000_0000, 1'b0, 1'b1, 32'hD0);
      respond(1'b1, 32'hD0);
      force_uncached = 1'b0;
      @(negedge clk) #2;
      chk("force_uncached_cnt", cnt_uncached, 3);
      chk("cached_total", cnt_cached, 7);
      chk("no_stray_yet", err_stray, 0);
      // stray response with nothing outstanding
      @(negedge clk);
      frombridge_data_ok = 1'b1;
      #2 chk("stray_data_ok", data_data_ok, 0);
      @(posedge clk); #1 frombridge_data_ok = 1'b0;
      @(negedge clk) #2 chk("stray_sticky", err_stray, 1);
      // reset in the middle of a read
      send(32'h8000_0200, 1'b0, 1'b0, 32'hE0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst = 1'b1;
      hold_req(32'h8000_0300);
      fromcache_rdata = 32'h1111; frombridge_rdata = 32'h2222;
      #2;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_stray", err_stray, 0);
      chk("mid_rst_addr_ok", data_addr_ok, 0);
      chk("mid_rst_cache_req", tocache_req, 0);
      chk("mid_rst_rdata", data_rdata, 32'h1111);
      chk("mid_rst_cnt", cnt_cached, 0);
      @(negedge clk);
      rst = 1'b0; data_req = 1'b0;
      @(negedge clk);
      fromcache_data_ok = 1'b1;
      #2 chk("post_rst_data_ok", data_data_ok, 0);
      @(posedge clk); #1 fromcache_data_ok = 1'b0;
      @(negedge clk) #2 chk("post_rst_stray", err_stray, 1);
      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dcache_route_mux.md
# dcache_route_mux

Per-request router for the CPU data sram-like port, placed between the MIPS core and the pair (data cache, AXI bridge data port). Replaces the static whole-port bypass switch. Each request is classed cached or uncached from its address plus a global force input. Outstanding transactions are tracked so every `data_ok` returns from the path that owns it, in issue order. Also provides stall/traffic counters for perf runs.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unanswered requests (≥1)
- `UC_MASK`, 32'hE000_0000, address bits compared for uncached class
- `UC_MATCH`, 32'hA000_0000, value under mask meaning uncached (kseg1)
- `CNT_W`, 32, perf counter width

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous, active-high
- `force_uncached` in 1: classify every request uncached
- `data_req`/`data_wr` in 1, `data_size` in 2, `data_addr` in ADDR_W, `data_wdata` in DATA_W: CPU request
- `data_rdata` out DATA_W, `data_addr_ok`/`data_data_ok` out 1: CPU response
- `tocache_req`/`tocache_wr` out 1, `tocache_size` out 2, `tocache_addr` out ADDR_W, `tocache_wdata` out DATA_W: request to dcache
- `fromcache_rdata` in DATA_W, `fromcache_addr_ok`/`fromcache_data_ok` in 1: dcache response
- `tobridge_req`/`tobridge_wr` out 1, `tobridge_size` out 2, `tobridge_addr` out ADDR_W, `tobridge_wdata` out DATA_W: uncached request to bridge
- `frombridge_rdata` in DATA_W, `frombridge_addr_ok`/`frombridge_data_ok` in 1: bridge response
- `busy` out 1: outstanding count nonzero
- `err_stray` out 1: sticky, data_ok seen from a path with nothing outstanding on it
- `cnt_cached`, `cnt_uncached`, `cnt_switch_stall` out CNT_W: perf counters

## Operation
- Class: `uc = force_uncached | ((data_addr & UC_MASK) == UC_MATCH)`; route 0 = cache, 1 = bridge.
- State: `route` (1 bit), `count` (0..MAX_OUTSTANDING).
- `issue_ok = !rst && (count == 0 || (uc == route && count < MAX_OUTSTANDING))`, evaluated on registered `count`/`route` only.
- Selected path gets `req = data_req & issue_ok` and CPU wr/size/addr/wdata; unselected path sees all request fields 0.
- `data_addr_ok` = selected path's addr_ok & issue_ok. Accept = `data_req & data_addr_ok`.
- Accept with `count == 0`: `route <= uc`.
- Retire = `count > 0` & data_ok of path `route`. `data_data_ok` = retire; `data_rdata` = rdata of path `route`.
- Next count = count + accept − retire; simultaneous accept/retire leaves it unchanged.
- Switch stall: `data_req`, `count > 0`, `uc != route` → nothing forwarded, `data_addr_ok = 0`, `cnt_switch_stall` +1 per cycle. Retiring to 0 in that cycle does not release it; accept happens the next cycle at earliest.
- Full (`count == MAX_OUTSTANDING`, same route): stalled, not counted as switch stall.
- `err_stray` set when a data_ok arrives from the non-`route` path, or from either path with `count == 0`; response dropped, cleared only by reset.
- Counters: `cnt_cached`/`cnt_uncached` +1 per accept by class; all counters saturate at all-ones.

## Timing
- Forward path combinational: request and addr_ok in the same cycle; response mux combinational (0 added latency).
- Registers update on `posedge clk`; `rst` asserted clears `count`, `route`, `err_stray` and counters to 0 immediately.
- While `rst` high: all `*_req`, `data_addr_ok`, `data_data_ok` = 0; `data_rdata` = `fromcache_rdata`; `busy` = 0.
- Reset mid-transaction: outstanding state discarded; later data_ok from either path with `count == 0` sets `err_stray` (bench treats this as expected after mid-op reset).

## Structure
- Shared package: `ROUTE_CACHE = 1'b0`, `ROUTE_BYPASS = 1'b1`, default `UC_MASK`/`UC_MATCH` constants.
- One sub-module `route_tracker` (count, route, issue_ok, retire, err_stray); the top level holds class decode, muxes and counters.

## Test plan
- Cached load at 0x8000_0010, cache addr_ok same cycle, data_ok 3 cycles later with 0x1234_5678 → `data_rdata` = 0x1234_5678; bridge req never asserted; `cnt_cached` = 1.
- Uncached store at 0xBFAF_0000 → `tobridge_req`, wr = 1, address passed; `tocache_req` stays 0; `cnt_uncached` = 1.
- Four back-to-back cached reads with data_ok withheld → 5th stalls with `data_addr_ok = 0`; first retire → 5th accepted the next cycle.
- Cached read outstanding, then uncached read → stalled until cached data_ok; accepted 1 cycle after count reaches 0; `cnt_switch_stall` equals stalled cycles.
- `force_uncached = 1`, access to 0x8000_0000 → routed to bridge.
- Spurious `frombridge_data_ok` with count 0 → `err_stray` = 1, no `data_data_ok`; `rst` pulse mid-read → count 0 and all outputs at reset values.
